pn_checker: RTL and testbench

PN_CHECKER -- requirements
Module: pn_checker

---
 rtl/pn_pkg.sv | 22 ++
 rtl/pn_lfsr_step.sv | 13 +
 rtl/pn_checker.sv | 175 +++++++++++++++++
 tb/tb_pn_checker.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pn_pkg.sv
// Shared PN-sequence definitions for the checker and the matching generator.
// Polynomial 1 + x^4 + x^5 + x^6 + x^8 over an 8-bit shift register; the
// predicted bit is pn[3] ^ pn[4] ^ pn[5] ^ pn[7].
package pn_pkg;

    // Shift-register width
    localparam int PN_W = 8;

    // Tap mask: a set bit means that pn bit feeds the XOR
    localparam logic [PN_W-1:0] PN_TAPS = 8'b1011_1000;

    // Valid bits needed to load the register before prediction is meaningful
    localparam int FILL_LEN = PN_W;

    // Checker FSM encoding
    typedef enum logic [1:0] {
        PN_FILL   = 2'd0,
        PN_SEARCH = 2'd1,
        PN_LOCKED = 2'd2
    } pn_state_e;

endpackage

// File: rtl/pn_lfsr_step.sv
// Combinational feedback for the PN polynomial: given the current register,
// produce the next sequence bit. Shared by checker and generator designs.
module pn_lfsr_step
    import pn_pkg::*;
(
    input  logic [PN_W-1:0] pn,
    output logic            next_bit
);

    // XOR of the tapped register bits
    assign next_bit = ^(pn & PN_TAPS);

endmodule

// File: rtl/pn_checker.sv
// PN-sequence checker: fills its register from the received stream, searches
// for LOCK_THRESH consecutive correct predictions, then free-runs and counts
// mispredicted bits, dropping lock when ERR_THRESH errors land in one window
// of WIN_LEN valid bits.
// Optional macro PN_CHECKER_BER_EN adds a 32-bit bit_cnt output that counts
// valid bits received while locked, so BER = err_cnt / bit_cnt.
module pn_checker
    import pn_pkg::*;
#(
    parameter int LOCK_THRESH = 16,
    parameter int WIN_LEN     = 64,
    parameter int ERR_THRESH  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        s_valid,
    input  logic        s_in,
    output logic        locked,
    output logic        err_pulse,
    output logic [15:0] err_cnt
`ifdef PN_CHECKER_BER_EN
    ,
    output logic [31:0] bit_cnt
`endif
);

    localparam logic [7:0]  LOCK_THRESH_C = 8'(LOCK_THRESH);
    localparam logic [15:0] WIN_LEN_C     = 16'(WIN_LEN);
    localparam logic [15:0] ERR_THRESH_C  = 16'(ERR_THRESH);
    localparam logic [3:0]  FILL_LAST_C   = 4'(FILL_LEN - 1);

    pn_state_e       state_q,     state_d;
    logic [PN_W-1:0] pn_q,        pn_d;
    logic [3:0]      fill_cnt_q,  fill_cnt_d;
    logic [7:0]      match_cnt_q, match_cnt_d;
    logic [15:0]     win_bit_q,   win_bit_d;
    logic [15:0]     win_err_q,   win_err_d;
    logic [15:0]     err_cnt_q,   err_cnt_d;
    logic            err_pulse_q, err_pulse_d;
`ifdef PN_CHECKER_BER_EN
    logic [31:0]     bit_cnt_q,   bit_cnt_d;
`endif

    logic            pred_bit;
    logic            mis;
    logic [7:0]      match_next;
    logic [15:0]     win_bit_next;
    logic [15:0]     win_err_next;

    // Predicted next bit from the current register contents
    pn_lfsr_step u_step (
        .pn       (pn_q),
        .next_bit (pred_bit)
    );

    // Next-state, register and counter updates; only valid bits advance anything
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
        state_d      = state_q;
        pn_d         = pn_q;
        fill_cnt_d   = fill_cnt_q;
        match_cnt_d  = match_cnt_q;
        win_bit_d    = win_bit_q;
        win_err_d    = win_err_q;
        err_cnt_d    = err_cnt_q;
        err_pulse_d  = 1'b0;
`ifdef PN_CHECKER_BER_EN
        bit_cnt_d    = bit_cnt_q;
`endif
        mis          = (s_in != pred_bit);
        match_next   = match_cnt_q + 8'd1;
        win_bit_next = win_bit_q + 16'd1;
        win_err_next = win_err_q + {15'd0, mis};

        if (s_valid) begin
            unique case (state_q)
                PN_FILL: begin
                    pn_d = {pn_q[PN_W-2:0], s_in};
                    if (fill_cnt_q == FILL_LAST_C) begin
                        fill_cnt_d = 4'd0;
                        state_d    = PN_SEARCH;
                    end else begin
                        fill_cnt_d = fill_cnt_q + 4'd1;
                    end
                end

                PN_SEARCH: begin
                    // Self-synchronising: the received bit enters the register
                    pn_d = {pn_q[PN_W-2:0], s_in};
                    // An all-zero register predicts zeros forever; never count it
                    if (pn_q == '0 || mis) begin
                        match_cnt_d = 8'd0;
                    end else if (match_next == LOCK_THRESH_C) begin
                        match_cnt_d = 8'd0;
                        win_bit_d   = 16'd0;
                        win_err_d   = 16'd0;
                        state_d     = PN_LOCKED;
                    end else begin
                        match_cnt_d = match_next;
                    end
                end

                PN_LOCKED: begin
                    // Free-running: the register follows its own prediction
                    pn_d = {pn_q[PN_W-2:0], pred_bit};
`ifdef PN_CHECKER_BER_EN
                    if (bit_cnt_q != 32'hFFFF_FFFF) bit_cnt_d = bit_cnt_q + 32'd1;
`endif
                    if (mis) begin
                        err_pulse_d = 1'b1;
                        if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
                    end
                    // Loss of lock wins over a coincident window end
                    if (mis && win_err_next == ERR_THRESH_C) begin
                        state_d     = PN_FILL;
                        pn_d        = '0;
                        fill_cnt_d  = 4'd0;
                        match_cnt_d = 8'd0;
                        win_bit_d   = 16'd0;
                        win_err_d   = 16'd0;
                    end else if (win_bit_next == WIN_LEN_C) begin
                        win_bit_d = 16'd0;
                        win_err_d = 16'd0;
                    end else begin
                        win_bit_d = win_bit_next;
                        win_err_d = win_err_next;
                    end
                end

                default: begin
                    state_d = PN_FILL;
                end
            endcase
        end
    end

    // State register with synchronous reset; enable low acts as a clear
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst || !enable) begin
            state_q     <= PN_FILL;
            pn_q        <= '0;
            fill_cnt_q  <= 4'd0;
            match_cnt_q <= 8'd0;
            win_bit_q   <= 16'd0;
            win_err_q   <= 16'd0;
            err_cnt_q   <= 16'd0;
            err_pulse_q <= 1'b0;
`ifdef PN_CHECKER_BER_EN
            bit_cnt_q   <= 32'd0;
`endif
        end else begin
            state_q     <= state_d;
            pn_q        <= pn_d;
            fill_cnt_q  <= fill_cnt_d;
            match_cnt_q <= match_cnt_d;
            win_bit_q   <= win_bit_d;
            win_err_q   <= win_err_d;
            err_cnt_q   <= err_cnt_d;
            err_pulse_q <= err_pulse_d;
`ifdef PN_CHECKER_BER_EN
            bit_cnt_q   <= bit_cnt_d;
`endif
        end
    end

    assign locked    = (state_q == PN_LOCKED);
    assign err_pulse = err_pulse_q;
    assign err_cnt   = err_cnt_q;
`ifdef PN_CHECKER_BER_EN
    assign bit_cnt   = bit_cnt_q;
`endif

endmodule

// File: tb/tb_pn_checker.sv
// Self-checking bench for pn_checker: a behavioural reference model pushes the
// expected outputs for every driven cycle into a queue, which is popped and
// compared one time unit after the clock edge. Directed milestone checks cover
// lock point, single error, loss/relock, window clearing, priority, all-zero
// input, sparse s_valid, reset and enable clear, and (with PN_CHECKER_BER_EN)
// the bit counter.
module tb_pn_checker;

    localparam int LT = 16;
    localparam int WL = 64;
    localparam int ET = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b1;
    logic        s_valid = 1'b0;
    logic        s_in = 1'b0;
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_cnt;
`ifdef PN_CHECKER_BER_EN
    logic [31:0] bit_cnt;
`endif

    pn_checker #(.LOCK_THRESH(LT), .WIN_LEN(WL), .ERR_THRESH(ET)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .s_valid   (s_valid),
        .s_in      (s_in),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_cnt   (err_cnt)
`ifdef PN_CHECKER_BER_EN
        ,
        .bit_cnt   (bit_cnt)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int pulses = 0;

    // Reference model state
    int          m_state;  // 0 fill, 1 search, 2 locked
    logic [7:0]  m_pn;
    int          m_fill, m_match, m_wbit, m_werr, m_err_cnt;
    longint      m_bit_cnt;
    logic        m_pulse;

    logic [7:0]  g_pn;          // golden generator register
    logic [63:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic pred(input logic [7:0] v);
        return v[3] ^ v[4] ^ v[5] ^ v[7];
    endfunction

    task automatic model(input logic r, input logic en, input logic v, input logic b);
        logic p;
        if (r || !en) begin
            m_state = 0; m_pn = 8'h00; m_fill = 0; m_match = 0; m_wbit = 0;
            m_werr = 0; m_err_cnt = 0; m_bit_cnt = 0; m_pulse = 1'b0;
        end else begin
            m_pulse = 1'b0;
            if (v) begin
                p = pred(m_pn);
                case (m_state)
                    0: begin
                        m_pn = {m_pn[6:0], b};
                        m_fill++;
                        if (m_fill == 8) begin m_state = 1; m_fill = 0; end
                    end
                    1: begin
                        if (m_pn == 8'h00 || b != p) m_match = 0;
                        else m_match++;
                        m_pn = {m_pn[6:0], b};
                        if (m_match == LT) begin
                            m_state = 2; m_match = 0; m_wbit = 0; m_werr = 0;
                        end
                    end
                    default: begin
                        m_pn = {m_pn[6:0], p};
                        if (m_bit_cnt < 64'hFFFF_FFFF) m_bit_cnt++;
                        m_wbit++;
                        if (b != p) begin
                            m_pulse = 1'b1;
                            if (m_err_cnt < 65535) m_err_cnt++;
                            m_werr++;
                        end
                        if (b != p && m_werr == ET) begin
                            m_state = 0; m_pn = 8'h00; m_fill = 0; m_match = 0;
                            m_wbit = 0; m_werr = 0;
                        end else if (m_wbit == WL) begin
                            m_wbit = 0; m_werr = 0;
                        end
                    end
                endcase
            end
        end
    endtask

    function automatic logic [63:0] model_vec();
        logic [31:0] bc;
`ifdef PN_CHECKER_BER_EN
        bc = 32'(m_bit_cnt);
`else
        bc = 32'd0;
`endif
        return {14'd0, (m_state == 2), m_pulse, 16'(m_err_cnt), bc};
    endfunction

    function automatic logic [63:0] dut_vec();
        logic [31:0] bc;
`ifdef PN_CHECKER_BER_EN
        bc = bit_cnt;
`else
        bc = 32'd0;
`endif
        return {14'd0, locked, err_pulse, err_cnt, bc};
    endfunction

    // One clock: drive inputs, queue the expectation, compare after the edge
    task automatic step(input logic v, input logic b, input logic r, input logic en);
        logic [63:0] e;
        rst = r; enable = en; s_valid = v; s_in = b;
        model(r, en, v, b);
        exp_q.push_back(model_vec());
        @(posedge clk);
        #1;
        if (err_pulse) pulses++;
        e = exp_q.pop_front();
        check("sb", dut_vec(), e);
    endtask

    // One golden bit (optionally inverted) preceded by gap idle cycles
    task automatic gold(input logic inv, input int gap);
        logic b;
        for (int i = 0; i < gap; i++) step(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b1);
        b = pred(g_pn);
        g_pn = {g_pn[6:0], b};
        step(1'b1, b ^ inv, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        g_pn = 8'h45;
        step(1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        pulses = 0;
    endtask

    // Feed clean golden bits until locked, bounded; returns valid bits used
    task automatic wait_lock(input int gap, output int n);
        n = 0;
        while (!locked && n < 200) begin
            gold(1'b0, gap);
            n++;
        end
    endtask

    initial begin
        int n;
        logic seen;

        // Reset state
        do_reset();
        check("rst_locked", 64'(locked), 64'd0);
        check("rst_err_pulse", 64'(err_pulse), 64'd0);
        check("rst_err_cnt", 64'(err_cnt), 64'd0);

        // Clean lock point and no errors while locking
        wait_lock(0, n);
        check("lock_pt", 64'(n), 64'd24);
        check("lock_no_pulse", 64'(pulses), 64'd0);

        // Single error, then window clearing: 7 errors in window 1, 1 in window 2
        for (int k = 1; k <= 80; k++) begin
            gold((k == 10) || (k >= 20 && k <= 30 && (k % 2) == 0) || (k == 70), 0);
            if (k == 10) begin
                check("one_err_pulse", 64'(err_pulse), 64'd1);
                check("one_err_cnt", 64'(err_cnt), 64'd1);
                check("one_err_locked", 64'(locked), 64'd1);
            end
            if (k == 11) check("one_err_pulse_gone", 64'(err_pulse), 64'd0);
        end
        check("win_clear_locked", 64'(locked), 64'd1);
        check("win_clear_err_cnt", 64'(err_cnt), 64'd8);
        check("win_clear_pulses", 64'(pulses), 64'd8);

        // Eight errors early in a window: loss of lock, relock, count retained
        do_reset();
        wait_lock(0, n);
        for (int k = 1; k <= 16; k++) begin
            gold((k % 2) == 0, 0);
            if (k == 14) check("pre_loss_locked", 64'(locked), 64'd1);
        end
        check("loss_locked", 64'(locked), 64'd0);
        check("loss_err_cnt", 64'(err_cnt), 64'd8);
        wait_lock(0, n);
        check("relock_pt", 64'(n), 64'd24);
        check("relock_err_cnt", 64'(err_cnt), 64'd8);

        // Eighth error on the last bit of the window: loss wins
        do_reset();
        wait_lock(0, n);
        for (int k = 1; k <= WL; k++) begin
            gold(k > WL - ET, 0);
            if (k == WL - 1) check("prio_pre_locked", 64'(locked), 64'd1);
        end
        check("prio_locked", 64'(locked), 64'd0);

        // enable=0 clears everything and ignores s_valid
        do_reset();
        wait_lock(0, n);
        gold(1'b1, 0);
        check("en_pre_err_cnt", 64'(err_cnt), 64'd1);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("en_clear", {46'd0, locked, err_pulse, err_cnt}, 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
            seen = seen | locked | err_pulse;
        end
        check("en_ignore", 64'(seen), 64'd0);

        // All-zero input never locks
        do_reset();
        seen = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b1);
            seen = seen | locked;
        end
        check("zeros_nolock", 64'(seen), 64'd0);

        // Sparse s_valid: same lock point in valid bits
        do_reset();
        wait_lock(2, n);
        check("slow_lock_pt", 64'(n), 64'd24);

        // Reset mid-SEARCH aborts progress: a full fill+search is needed again
        do_reset();
        for (int i = 0; i < 14; i++) gold(1'b0, 2);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        check("mid_rst_out", {46'd0, locked, err_pulse, err_cnt}, 64'd0);
        g_pn = 8'h45;
        wait_lock(0, n);
        check("mid_rst_relock_pt", 64'(n), 64'd24);

`ifdef PN_CHECKER_BER_EN
        // 1000 locked bits with 3 errors
        do_reset();
        wait_lock(0, n);
        for (int k = 1; k <= 1000; k++) gold((k == 100) || (k == 400) || (k == 700), 0);
        check("ber_bit_cnt", 64'(bit_cnt), 64'd1000);
        check("ber_err_cnt", 64'(err_cnt), 64'd3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
